// File: rtl/rob_pkg.sv
// Shared defaults and FSM encoding for the reorder-buffer release controller.
package rob_pkg;

    localparam int ROB_DEPTH  = 8;
    localparam int ROB_AWIDTH = 3;
    localparam int ROB_WIDTH  = 34;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } rob_state_e;

endpackage

// File: rtl/rmem.sv
// Reorder-buffer storage: synchronous write port, read port with a registered address
// (rdata follows the address captured on the last rden pulse).
module rmem #(
    parameter int DEPTH  = 8,
    parameter int AWIDTH = 3,
    parameter int WIDTH  = 34
) (
    input  logic              wclk,
    input  logic              wren,
    input  logic [AWIDTH-1:0] waddress,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rclk,
    input  logic              rden,
    input  logic [AWIDTH-1:0] raddress,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AWIDTH-1:0] raddr_q;

    always_ff @(posedge wclk) begin
        if (wren) begin
            mem_q[waddress] <= wdata;
        end
    end

    always_ff @(posedge rclk) begin
        if (rden) begin
            raddr_q <= raddress;
        end
    end

    assign rdata = mem_q[raddr_q];

endmodule

// File: rtl/rob_ctrl.sv
// In-order release controller in front of rmem: hands out tags in order, stores out-of-order
// completions, retires in allocation order. Defining ROB_FLUSH_EN adds a synchronous flush input.
module rob_ctrl
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int AWIDTH = ROB_AWIDTH,
    parameter int WIDTH  = ROB_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ROB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [AWIDTH-1:0] alloc_tag,
    input  logic              cpl_valid,
    input  logic [AWIDTH-1:0] cpl_tag,
    input  logic [WIDTH-1:0]  cpl_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] out_tag,
    output logic [WIDTH-1:0]  out_data,
    output logic [AWIDTH:0]   count,
    output logic              full,
    output logic              empty,
    output logic              dbg_state
);

    localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);
    localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH:0]   CNT_FULL = (AWIDTH + 1)'(DEPTH);

    logic [AWIDTH-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
    logic [AWIDTH:0]   count_q, count_d;
    logic [DEPTH-1:0]  alloc_q, alloc_d, done_q, done_d;
    rob_state_e        state_q, state_d;
    logic              hs, cpl_ok, rden;
    logic [AWIDTH-1:0] raddress;

    assign count     = count_q;
    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign alloc_tag = tail_q;
    assign out_tag   = head_q;
    assign out_valid = (state_q == PRESENT);
    assign dbg_state = state_q;
    assign head_nxt  = head_q + PTR_ONE;

    // Output port is valid/ready: an entry transfers on a cycle where out_valid and out_ready
    // are both high; out_valid never falls without that transfer, and out_data holds meanwhile.
    assign hs = out_valid & out_ready;

`ifdef ROB_FLUSH_EN
    assign alloc_gnt = alloc_req & ~full & ~flush;
    assign cpl_ok    = cpl_valid & alloc_q[cpl_tag] & ~done_q[cpl_tag] & ~flush;
`else
    assign alloc_gnt = alloc_req & ~full;
    assign cpl_ok    = cpl_valid & alloc_q[cpl_tag] & ~done_q[cpl_tag];
`endif

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        alloc_d  = alloc_q;
        done_d   = done_q;
        state_d  = state_q;
        rden     = 1'b0;
        raddress = head_q;

        if (alloc_gnt) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + PTR_ONE;
        end
        // A done slot never accepts a second write, so the presented entry cannot change.
        if (cpl_ok) begin
            done_d[cpl_tag] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (done_q[head_q]) begin
                    rden    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (hs) begin
                    alloc_d[head_q] = 1'b0;
                    done_d[head_q]  = 1'b0;
                    head_d          = head_nxt;
                    if (done_q[head_nxt]) begin
                        rden     = 1'b1;
                        raddress = head_nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case ({alloc_gnt, hs})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

`ifdef ROB_FLUSH_EN
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            alloc_d = '0;
            done_d  = '0;
            state_d = IDLE;
            rden    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            state_q <= IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    rmem #(
        .DEPTH (DEPTH),
        .AWIDTH(AWIDTH),
        .WIDTH (WIDTH)
    ) u_rmem (
        .wclk    (clk),
        .wren    (cpl_ok),
        .waddress(cpl_tag),
        .wdata   (cpl_data),
        .rclk    (clk),
        .rden    (rden),
        .raddress(raddress),
        .rdata   (out_data)
    );

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: per-cycle comparison against a slot-level model plus literal
// checks of retired tag/data pairs. Define ROB_FLUSH_EN to also exercise flush.
module tb_rob_ctrl;

  localparam int DEPTH  = 8;
  localparam int AWIDTH = 3;
  localparam int WIDTH  = 34;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alloc_req = 1'b0;
  logic              cpl_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              flush = 1'b0;
  logic [AWIDTH-1:0] cpl_tag = '0;
  logic [WIDTH-1:0]  cpl_data = '0;
  logic              alloc_gnt, out_valid, full, empty, dbg_state;
  logic [AWIDTH-1:0] alloc_tag, out_tag;
  logic [WIDTH-1:0]  out_data;
  logic [AWIDTH:0]   count;

  int n_checks = 0;
  int n_err = 0;
  logic [AWIDTH+WIDTH-1:0] exp_q[$];

  rob_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ROB_FLUSH_EN
    .flush    (flush),
`endif
    .alloc_req(alloc_req),
    .alloc_gnt(alloc_gnt),
    .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid),
    .cpl_tag  (cpl_tag),
    .cpl_data (cpl_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tag  (out_tag),
    .out_data (out_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which slots are allocated/completed, their data, head/tail and whether the head
  // is being presented. An entry is presented the cycle after it is head with its completion
  // already recorded, and stays until taken.
  int               m_count, m_head, m_tail, m_nh;
  bit               m_alloc[DEPTH];
  bit               m_done[DEPTH];
  logic [WIDTH-1:0] m_data[DEPTH];
  bit               m_valid, m_gnt, m_hs, m_ok, m_nv;

  task automatic model_clear();
    m_count = 0; m_head = 0; m_tail = 0; m_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_alloc[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      m_gnt = alloc_req && (m_count < DEPTH) && !flush;
      m_hs  = m_valid && out_ready;
      m_ok  = cpl_valid && m_alloc[cpl_tag] && !m_done[cpl_tag];
      m_nh  = m_hs ? (m_head + 1) % DEPTH : m_head;
      m_nv  = m_done[m_nh];
      if (flush) begin
        model_clear();
      end else begin
        if (m_hs) begin
          m_alloc[m_head] = 1'b0;
          m_done[m_head]  = 1'b0;
          m_count--;
        end
        if (m_gnt) begin
          m_alloc[m_tail] = 1'b1;
          m_done[m_tail]  = 1'b0;
          m_tail = (m_tail + 1) % DEPTH;
          m_count++;
        end
        if (m_ok) begin
          m_done[cpl_tag] = 1'b1;
          m_data[cpl_tag] = cpl_data;
        end
        m_head  = m_nh;
        m_valid = m_nv;
      end
    end
  end

  // compare process + scoreboard of retired entries
  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("dbg_state", dbg_state, m_valid);
    chk("count", count, m_count);
    chk("full", full, m_count == DEPTH);
    chk("empty", empty, m_count == 0);
    chk("alloc_gnt", alloc_gnt, alloc_req && (m_count < DEPTH) && !flush);
    if (alloc_gnt) chk("alloc_tag", alloc_tag, m_tail);
    if (m_valid) begin
      chk("out_tag", out_tag, m_head);
      chk("out_data", out_data, m_data[m_head]);
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL retire_unexpected: got tag %0d data 0x%0h required no retire", out_tag, out_data);
      end else begin
        chk("retire", {out_tag, out_data}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    chk("exp_drained", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0; alloc_req = 1'b0; cpl_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input int n, input int first_tag);
    alloc_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("alloc_tag_lit", alloc_tag, (first_tag + i) % DEPTH);
      tick();
    end
    alloc_req = 1'b0;
  endtask

  task automatic cpl(input int tag, input logic [WIDTH-1:0] data);
    cpl_valid = 1'b1;
    cpl_tag   = AWIDTH'(tag);
    cpl_data  = data;
    tick();
    cpl_valid = 1'b0;
  endtask

  task automatic expect_ret(input int tag, input logic [WIDTH-1:0] data);
    exp_q.push_back({AWIDTH'(tag), data});
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 20; k++) begin
      if (out_valid) break;
      tick();
    end
    n_checks++;
    if (k == 20) begin
      n_err++;
      $display("FAIL wait_valid: got out_valid=0 for 20 cycles required 1");
    end
  endtask

  initial begin
    // reset state
    tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    tick();
    rst_n = 1'b1;

    // 1: in-order completion, back-to-back release
    out_ready = 1'b1;
    alloc(3, 0);
    expect_ret(0, 34'h1); expect_ret(1, 34'h2); expect_ret(2, 34'h3);
    cpl(0, 34'h1); cpl(1, 34'h2); cpl(2, 34'h3);
    idle(6);
    @(negedge clk);
    chk("t1_empty", empty, 1);
    tick();

    // 2: reverse completion, nothing released until the head completes
    do_reset();
    out_ready = 1'b1;
    alloc(4, 0);
    cpl(3, 34'h30); cpl(2, 34'h20); cpl(1, 34'h10);
    idle(2);
    @(negedge clk);
    chk("t2_no_valid", out_valid, 0);
    tick();
    expect_ret(0, 34'h00); expect_ret(1, 34'h10); expect_ret(2, 34'h20); expect_ret(3, 34'h30);
    cpl(0, 34'h00);
    idle(7);
    @(negedge clk);
    chk("t2_empty", empty, 1);
    tick();

    // 3: fill, blocked request, retire with wrap
    do_reset();
    alloc_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("t3_tag", alloc_tag, i);
      tick();
    end
    @(negedge clk);
    chk("t3_full", full, 1);
    chk("t3_count", count, 8);
    chk("t3_gnt_blocked", alloc_gnt, 0);
    tick();
    cpl(0, 34'h55);
    wait_valid();
    out_ready = 1'b1;
    expect_ret(0, 34'h55);
    @(negedge clk);
    chk("t3_gnt_blocked_retire", alloc_gnt, 0);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_not_full", full, 0);
    chk("t3_gnt", alloc_gnt, 1);
    chk("t3_wrap_tag", alloc_tag, 0);
    tick();
    alloc_req = 1'b0;
    idle(2);

    // 4: stall with duplicate completion to the presented head
    do_reset();
    alloc(2, 0);
    cpl(0, 34'h0AB);
    wait_valid();
    cpl_valid = 1'b1; cpl_tag = 3'd0; cpl_data = 34'h3FFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 34'h0AB);
      tick();
      cpl_valid = 1'b0;
    end
    out_ready = 1'b1;
    expect_ret(0, 34'h0AB);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_after_retire", out_valid, 0);
    tick();

    // 5: completion to an unallocated tag is dropped
    do_reset();
    out_ready = 1'b1;
    alloc(5, 0);
    cpl(5, 34'h5);
    @(negedge clk);
    chk("t5_count", count, 5);
    tick();
    for (int i = 0; i < 5; i++) begin
      expect_ret(i, WIDTH'(34'h10 + i));
      cpl(i, WIDTH'(34'h10 + i));
    end
    idle(6);
    @(negedge clk);
    chk("t5_slot5_idle", out_valid, 0);
    chk("t5_empty", empty, 1);
    tick();
    alloc(1, 5);
    expect_ret(5, 34'h99);
    cpl(5, 34'h99);
    idle(4);
    @(negedge clk);
    chk("t5_end_empty", empty, 1);
    tick();

`ifdef ROB_FLUSH_EN
    // 6: flush beats alloc, completion and handshake
    do_reset();
    alloc(4, 0);
    cpl(0, 34'h7);
    wait_valid();
    flush = 1'b1; alloc_req = 1'b1; out_ready = 1'b1;
    cpl_valid = 1'b1; cpl_tag = 3'd1; cpl_data = 34'h11;
    @(negedge clk);
    chk("t6_gnt_forced", alloc_gnt, 0);
    tick();
    flush = 1'b0; alloc_req = 1'b0; cpl_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_valid", out_valid, 0);
    tick();
    alloc(1, 0);
    idle(2);
`endif

    idle(2);
    chk("exp_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
In-order release controller for the reorder buffer storage. It allocates tags in order and accepts completions out of order, writing each completion into the rmem storage array at its tag. It then reads entries back in allocation order and presents them on a valid/ready output port. It sits directly in front of rmem: it drives rmem's write port and read port, and consumes rmem's registered-address read data.

Parameters:
DEPTH, 8, number of slots; must equal 2**AWIDTH.
AWIDTH, 3, tag/pointer width.
WIDTH, 34, payload width.

Ports:
clk  in  1  single clock; drives both rmem wclk and rclk.
rst_n  in  1  reset, asynchronous, active-low.
alloc_req  in  1  request a new tag.
alloc_gnt  out  1  tag granted this cycle; alloc_gnt = alloc_req & ~full (combinational).
alloc_tag  out  AWIDTH  tag granted; equals tail pointer.
cpl_valid  in  1  completion strobe.
cpl_tag  in  AWIDTH  slot being completed.
cpl_data  in  WIDTH  completion payload.
out_valid  out  1  head entry presented.
out_ready  in  1  consumer accepts.
out_tag  out  AWIDTH  tag of presented entry (head).
out_data  out  WIDTH  payload of presented entry (rmem rdata).
count  out  AWIDTH+1  allocated, unretired entries.
full  out  1  count == DEPTH.
empty  out  1  count == 0.

Behaviour:
- State: head, tail (AWIDTH, wrap naturally mod DEPTH); count (AWIDTH+1); per-slot alloc[] and done[] bits; FSM {IDLE, PRESENT}.
- Reset values: head=tail=0; count=0; alloc[]=done[]=0; FSM=IDLE; out_valid=0; full=0; empty=1. rmem contents and its read address are not reset; out_data is don't-care while out_valid=0.
- Allocation: on alloc_gnt, set alloc[tail], clear done[tail], and increment tail. When full, the request is blocked even if a retire occurs in the same cycle.
- Completion: accepted only if alloc[cpl_tag]=1 and done[cpl_tag]=0. On accept, drive rmem wren=1, waddress=cpl_tag, wdata=cpl_data, and set done[cpl_tag].
  - Completion to an unallocated or already-done tag is silently dropped (no write). This protects the slot currently presented.
- IDLE -> PRESENT: when done[head]=1 (registered value), pulse rden with raddress=head. out_valid=1 from the following cycle.
  - Minimum latency: completion accepted at edge E, out_valid high after edge E+1.
- PRESENT: out_valid=1; out_data=rdata, held stable until handshake (slot cannot be rewritten while done=1).
- Handshake (out_valid & out_ready):
  - clear alloc[head] and done[head], increment head;
  - if done[head+1]=1, pulse rden with head+1 and stay in PRESENT (back-to-back, 1 entry/cycle); otherwise go to IDLE.
- count: +1 on grant, -1 on handshake, unchanged when both occur in the same cycle.
- out_valid never drops without a handshake, except on reset.
- Reset asserted mid-operation: all entries are discarded; out_valid deasserts asynchronously.

Optional Feature:
ROB_FLUSH_EN: adds input port flush (1 bit).
- flush=1 at an edge: head=tail=0, count=0, alloc[]=done[]=0, FSM=IDLE; out_valid=0 next cycle.
- flush has priority over alloc, cpl and handshake in the same cycle; alloc_gnt is forced to 0 while flush=1.
- Without the macro: no flush port and no flush logic.

Decomposition:
- Package rob_pkg: default DEPTH/AWIDTH/WIDTH constants; FSM state typedef (IDLE=1'b0, PRESENT=1'b1).
- One sub-module instance: rmem (storage), with wclk=rclk=clk. All control logic stays in rob_ctrl.

Test Plan:
1. Reset; alloc 3 tags; complete in order 0,1,2 with data 0x1,0x2,0x3; out_ready=1 -> alloc_tag 0,1,2; outputs tag0/0x1, tag1/0x2, tag2/0x3 on consecutive cycles; empty=1 at end.
2. Alloc tags 0..3; complete 3,2,1 then 0 (data 0x30,0x20,0x10,0x00) -> no out_valid until tag0 completes; then 0,1,2,3 emitted in order, back-to-back.
3. Alloc 8 -> full=1, count=8; alloc_req held -> alloc_gnt=0. Then complete and retire one -> full=0 and alloc_tag=0 (wrap).
4. out_ready=0 for 5 cycles while out_valid=1; duplicate completion to the head tag with 0x3FFFFFFFF -> out_data unchanged; retire on out_ready=1.
5. Completion to an unallocated tag 5 -> no rmem write, done[5]=0, count unchanged.
6. (ROB_FLUSH_EN) 4 entries in flight; flush for 1 cycle together with alloc_req and cpl_valid -> count=0, empty=1, out_valid=0, alloc_gnt=0; next alloc_tag=0.
